// File: rtl/ifid_stall_ctrl.sv
// ---------------------------------------------------------------------------
// ifid_stall_ctrl
//
// IF/ID pipeline register for the 5-stage pipeline, with the stall and flush
// sequencing built in.
//
// Each cycle it captures the fetched instruction and its PC+4. The Rs/Rt
// fields of the held instruction go to the load-use hazard detector. The
// block reacts to that detector's squash request and to the EX-stage taken
// branch:
//   - a load-use stall freezes the PC and IF/ID and injects a bubble into
//     ID/EX;
//   - a taken branch replaces the next FLUSH_DEPTH wrong-path slots with NOPs.
//
// Instruction buses use big-endian bit numbering: bit 0 is the MSB.
//
// Parameters:
//   NOP_INSTR    encoding loaded into IF/ID on reset or flush
//   FLUSH_DEPTH  NOP slots loaded after a taken branch (1..7)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   freeze        global pipeline hold; highest priority after reset
//   squash        load-use stall request from the hazard detector
//   branch_taken  EX-stage taken branch or jump
//   instr_in      fetched instruction
//   pc4_in        PC+4 of the fetched instruction
//   ifid_instr    registered instruction
//   ifid_pc4      registered PC+4
//   ifid_valid    IF/ID holds a real instruction (not a NOP or bubble)
//   ifid_rs       ifid_instr[6:10], combinational
//   ifid_rt       ifid_instr[11:15], combinational
//   pc_we         PC write enable, combinational
//   idex_bubble   zero the ID/EX control word on the next edge, combinational
//   stall_cnt     number of stall cycles, saturating
//   flush_cnt     number of flushed slots, saturating
//
// Configuration macro:
//   IFID_PERF_CNT_EN  when defined, stall_cnt and flush_cnt are real
//                     counters. Otherwise both are tied to zero.
// ---------------------------------------------------------------------------
module ifid_stall_ctrl #(
  parameter logic [0:31] NOP_INSTR   = 32'h5400_0000,
  parameter int unsigned FLUSH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        squash,
  input  logic        branch_taken,
  input  logic [0:31] instr_in,
  input  logic [31:0] pc4_in,
  output logic [0:31] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [4:0]  ifid_rs,
  output logic [4:0]  ifid_rt,
  output logic        pc_we,
  output logic        idex_bubble,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t     state, next_state;
  logic [2:0] fcnt, next_fcnt;
  logic       stl;
  logic       load_nop;
  logic       load_in;

  // Register fields go straight to the hazard detector.
  assign ifid_rs = ifid_instr[6:10];
  assign ifid_rt = ifid_instr[11:15];

  // A NOP in ID never stalls. A taken branch in the same cycle wins over the
  // squash request, because the instruction being stalled is on the wrong
  // path anyway.
  assign stl = squash & ifid_valid & (state == RUN) & ~branch_taken;

  // Next-state and control decode.
  // pc_we and idex_bubble must be valid in the same cycle as squash and
  // branch_taken, so they are decoded here and not registered.
  always_comb begin
    next_state  = state;
    next_fcnt   = fcnt;
    pc_we       = 1'b1;
    idex_bubble = 1'b0;
    load_nop    = 1'b0;
    load_in     = 1'b0;
    if (!rst_n) begin
      pc_we       = 1'b1;
      idex_bubble = 1'b0;
    end else if (freeze) begin
      pc_we = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            load_nop = 1'b1;
            // The branch edge already loads the first NOP, so FLUSH covers
            // the remaining FLUSH_DEPTH-1 slots. fcnt counts down to 0.
            if (FLUSH_DEPTH > 1) begin
              next_state = FLUSH;
              next_fcnt  = 3'(FLUSH_DEPTH - 2);
            end
          end else if (stl) begin
            pc_we       = 1'b0;
            idex_bubble = 1'b1;
          end else begin
            load_in = 1'b1;
          end
        end
        FLUSH: begin
          load_nop = 1'b1;
          if (fcnt == 3'd0) begin
            next_state = RUN;
          end else begin
            next_fcnt = fcnt - 3'd1;
          end
        end
        default: begin
          next_state = RUN;
          next_fcnt  = 3'd0;
        end
      endcase
    end
  end

  // State register and the IF/ID pipeline register.
  // Reset also aborts any stall or flush that is in progress.
  // While frozen, no load is decoded, so everything here holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      fcnt       <= 3'd0;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      state <= next_state;
      fcnt  <= next_fcnt;
      if (load_nop) begin
        ifid_instr <= NOP_INSTR;
        ifid_pc4   <= 32'd0;
        ifid_valid <= 1'b0;
      end else if (load_in) begin
        ifid_instr <= instr_in;
        ifid_pc4   <= pc4_in;
        ifid_valid <= 1'b1;
      end
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Performance counters.
  // They count unfrozen stall cycles and flush NOP loads, and saturate
  // at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (!freeze && stl && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (load_nop && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: doc/ifid_stall_ctrl.md
# ifid_stall_ctrl

IF/ID pipeline register with integrated stall/flush sequencing for the 5-stage pipeline. Captures the fetched instruction and PC+4 each cycle, and presents the decoded Rs/Rt fields to the load-use hazard detector. Consumes that detector's `squash` and the EX-stage `branch_taken`. It freezes the PC and IF/ID when a stall is required, injects a bubble into ID/EX, and replaces wrong-path instructions with NOPs after a taken branch.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h5400_0000: encoding loaded into IF/ID on reset or flush (opcode 6'b010101).
- `FLUSH_DEPTH`, default 1, legal range 1..7: number of consecutive cycles IF/ID is loaded with NOP after a taken branch.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `freeze`, in, 1: global pipeline hold (memory wait); highest priority after reset.
- `squash`, in, 1: load-use hazard request from the hazard detector.
- `branch_taken`, in, 1: EX-stage taken branch or jump.
- `instr_in`, in, 32: fetched instruction; bit 0 is MSB.
- `pc4_in`, in, 32: PC+4 of the fetched instruction.
- `ifid_instr`, out, 32: registered instruction.
- `ifid_pc4`, out, 32: registered PC+4.
- `ifid_valid`, out, 1: IF/ID holds a real instruction (not NOP or bubble).
- `ifid_rs`, out, 5: `ifid_instr[6:10]`, combinational.
- `ifid_rt`, out, 5: `ifid_instr[11:15]`, combinational.
- `pc_we`, out, 1: PC write enable, combinational.
- `idex_bubble`, out, 1: zero ID/EX control on the next edge, combinational.
- `stall_cnt`, out, 16: stall-cycle count.
- `flush_cnt`, out, 16: flushed-slot count.

## Operation
- FSM has two states, RUN and FLUSH. A 3-bit `fcnt` counts down the remaining flush slots.
- Effective stall `stl = squash & ifid_valid & (state==RUN) & ~branch_taken`. A NOP in ID never stalls.
- When `freeze`=1:
  - All registers, the FSM and the counters hold.
  - `pc_we`=0 and `idex_bubble`=0.
- RUN with `branch_taken`=1:
  - IF/ID loads `NOP_INSTR`, `ifid_pc4`=0, `ifid_valid`=0, `pc_we`=1.
  - If `FLUSH_DEPTH`>1, go to FLUSH with `fcnt=FLUSH_DEPTH-2`; otherwise stay in RUN.
  - `branch_taken` overrides `squash` in the same cycle.
- RUN with `stl`=1:
  - IF/ID holds, `pc_we`=0, `idex_bubble`=1.
  - Stall repeats every cycle `stl` stays high. There is no limit.
- RUN otherwise:
  - IF/ID loads `instr_in`/`pc4_in`, `ifid_valid`=1, `pc_we`=1, `idex_bubble`=0.
- FLUSH:
  - IF/ID loads NOP, `ifid_valid`=0, `pc_we`=1.
  - `squash` and `branch_taken` are ignored; EX holds a bubble.
  - When `fcnt`==0, go to RUN; otherwise decrement `fcnt`.
- Counters:
  - `stall_cnt` increments on each unfrozen edge with `stl`=1.
  - `flush_cnt` increments on each unfrozen edge that loads a flush NOP.
  - Both saturate at 16'hFFFF.

## Timing
- Reset, on the first rising edge with `rst_n`=0:
  - `ifid_instr`=`NOP_INSTR`, `ifid_pc4`=0, `ifid_valid`=0.
  - State RUN, `fcnt`=0, both counters 0.
- While `rst_n`=0: `pc_we`=1 and `idex_bubble`=0.
- Reset mid-stall or mid-flush aborts the sequence immediately; the next cycle is RUN.
- Latency: `instr_in` appears on `ifid_instr` one edge after capture.
- `pc_we` and `idex_bubble` are valid in the same cycle as `squash`/`branch_taken`. They have no register stage.
- Load-use case: `squash` is high for exactly one cycle. The bubble reaches ID/EX on that edge, the detector then deasserts, and IF/ID advances on the following edge.
- `branch_taken` and `squash` in the same cycle: flush wins, with 0 stall cycles counted.
- `freeze` asserted during FLUSH: `fcnt` holds; the flush resumes after release with no slots lost.

## Configuration
- Macro: `IFID_PERF_CNT_EN`.
- Defined: `stall_cnt` and `flush_cnt` are implemented as described.
- Undefined:
  - Counter registers are omitted.
  - `stall_cnt` and `flush_cnt` are tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- Reset then run: `rst_n`=0 for 2 cycles, then feed `instr_in`=32'h8C22_0004, `pc4_in`=32'h0000_0104.
  - During reset: `ifid_instr`=32'h5400_0000, `ifid_valid`=0.
  - One edge after release: `ifid_instr`=32'h8C22_0004, `ifid_rs`=1, `ifid_rt`=2, `ifid_valid`=1.
- Load-use stall: `ifid_valid`=1 and `squash`=1 for one cycle.
  - That cycle: `pc_we`=0, `idex_bubble`=1, IF/ID unchanged, `stall_cnt`=1 after the edge.
  - Next cycle: normal capture resumes.
- Squash on NOP: `squash`=1 while `ifid_valid`=0 gives `pc_we`=1, `idex_bubble`=0, and no count.
- Branch flush with `FLUSH_DEPTH`=3: pulse `branch_taken` for 1 cycle.
  - Three consecutive edges load NOP with `ifid_valid`=0; `squash` is ignored throughout.
  - The fourth edge captures `instr_in`; `flush_cnt`=3.
- Priority: `branch_taken`=1 with `squash`=1 and `ifid_valid`=1 gives `pc_we`=1, `idex_bubble`=0, and a NOP loaded.
  - Then `freeze`=1 for 2 cycles in FLUSH: all outputs hold and `pc_we`=0.
- Saturation, with `IFID_PERF_CNT_EN` defined: hold `stl` for 65 540 cycles → `stall_cnt`=16'hFFFF.
  - Without the macro: `stall_cnt`=0.
